// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit RF+ALU datapath: fetch/decode/exec/mem/write-back sequencing.
// Outputs are decoded combinationally from the registered state, Instr and Mem_Ready (no output register).
// FETCH and MEM stall while Mem_Ready is low; optional conditional branches under `CTRL_BRANCH_EN.
module multi_cycle_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Instr,
    input  logic [3:0]  NZVC,
    input  logic        Mem_Ready,
    output logic        Mem_Req,
    output logic        Mem_Write,
    output logic        IorD,
    output logic        IR_CE,
    output logic        PC_Write_en,
    output logic        RF_Write_en,
    output logic        ALUOut_CE,
    output logic        ALU_A_Sel,
    output logic        ALU_Control,
    output logic        MemtoReg,
    output logic [1:0]  ALU_B_Sel,
    output logic [1:0]  Imm_Sel,
    output logic [2:0]  Rd_to_RF,
    output logic [2:0]  Rm_Rd_to_RF,
    output logic [2:0]  Rn_to_RF,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_MEM    = 3'd4,
        S_LDWB   = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t     state;
    logic [4:0] opcode;
    logic       is_alu, is_reg_form, is_sub, is_addi8, is_ldr, is_str, is_br, is_halt;

    assign opcode      = Instr[15:11];
    assign is_alu      = (opcode <= 5'b00100);
    assign is_reg_form = (opcode == 5'b00000) || (opcode == 5'b00001);
    assign is_sub      = (opcode == 5'b00001) || (opcode == 5'b00011);
    assign is_addi8    = (opcode == 5'b00100);
    assign is_ldr      = (opcode == 5'b01000);
    assign is_str      = (opcode == 5'b01001);
    assign is_halt     = (opcode == 5'b11111);

`ifdef CTRL_BRANCH_EN
    logic [3:0] flags;
    logic       br_taken;

    assign is_br = (opcode == 5'b10000);

    // Condition evaluation on the stored flags: [3]=N [2]=Z [1]=V [0]=C
    always_comb begin
        case (Instr[10:8])
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = flags[2];
            3'b010:  br_taken = ~flags[2];
            3'b011:  br_taken = flags[3];
            3'b100:  br_taken = ~flags[3];
            3'b101:  br_taken = flags[0];
            3'b110:  br_taken = ~flags[0];
            default: br_taken = flags[1];
        endcase
    end

    // Flags are captured only at the end of EXEC of an ALU op, so loads/stores leave them intact
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags <= 4'b0000;
        else if (state == S_EXEC && is_alu)
            flags <= NZVC;
    end

    logic unused_bits;
    assign unused_bits = ^Instr[1:0];
`else
    assign is_br = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{Instr[1:0], NZVC, is_br};
`endif

    // Next-state sequencing; memory states hold until Mem_Ready is seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  if (Mem_Ready) state <= S_DECODE;
                S_DECODE: begin
`ifdef CTRL_BRANCH_EN
                    if (is_br)                        state <= S_BRANCH;
                    else
`endif
                    if (is_halt)                      state <= S_HALT;
                    else if (is_alu || is_ldr || is_str) state <= S_EXEC;
                    else                              state <= S_FETCH;
                end
                S_EXEC:   state <= (is_ldr || is_str) ? S_MEM : S_WB;
                S_WB:     state <= S_FETCH;
                S_MEM:    if (Mem_Ready) state <= is_ldr ? S_LDWB : S_FETCH;
                S_LDWB:   state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Datapath controls decoded from state; reset forces every output to its idle value at once
    always_comb begin
        Mem_Req     = 1'b0;
        Mem_Write   = 1'b0;
        IorD        = 1'b0;
        IR_CE       = 1'b0;
        PC_Write_en = 1'b0;
        RF_Write_en = 1'b0;
        ALUOut_CE   = 1'b0;
        ALU_A_Sel   = 1'b0;
        ALU_Control = 1'b0;
        MemtoReg    = 1'b0;
        ALU_B_Sel   = 2'b00;
        Imm_Sel     = 2'b00;
        Rd_to_RF    = 3'b000;
        Rm_Rd_to_RF = 3'b000;
        Rn_to_RF    = 3'b000;
        if (!rst) begin
            if (state != S_FETCH && state != S_HALT) begin
                Rd_to_RF    = Instr[10:8];
                Rm_Rd_to_RF = is_addi8 ? Instr[10:8] : Instr[7:5];
                Rn_to_RF    = is_str ? Instr[10:8] : Instr[4:2];
            end
            case (state)
                S_FETCH: begin
                    Mem_Req   = 1'b1;
                    ALU_B_Sel = 2'b11;
                    if (Mem_Ready) begin
                        IR_CE       = 1'b1;
                        PC_Write_en = 1'b1;
                    end
                end
                S_EXEC: begin
                    ALU_A_Sel   = 1'b1;
                    ALUOut_CE   = 1'b1;
                    ALU_B_Sel   = is_reg_form ? 2'b00 : 2'b01;
                    Imm_Sel     = is_addi8 ? 2'b01 : 2'b00;
                    ALU_Control = is_sub;
                end
                S_WB: RF_Write_en = 1'b1;
                S_MEM: begin
                    Mem_Req   = 1'b1;
                    IorD      = 1'b1;
                    Mem_Write = is_str;
                end
                S_LDWB: begin
                    RF_Write_en = 1'b1;
                    MemtoReg    = 1'b1;
                end
`ifdef CTRL_BRANCH_EN
                S_BRANCH: if (br_taken) begin
                    ALU_B_Sel   = 2'b01;
                    Imm_Sel     = 2'b01;
                    PC_Write_en = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign State = state;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench: a per-instruction reference model pushes the expected output vector for every cycle,
// a negedge monitor pops and compares against the DUT. Mem_Ready waits and flags are randomized.
module tb_multi_cycle_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Instr;
    logic [3:0]  NZVC;
    logic        Mem_Ready;
    logic        Mem_Req, Mem_Write, IorD, IR_CE, PC_Write_en, RF_Write_en;
    logic        ALUOut_CE, ALU_A_Sel, ALU_Control, MemtoReg;
    logic [1:0]  ALU_B_Sel, Imm_Sel;
    logic [2:0]  Rd_to_RF, Rm_Rd_to_RF, Rn_to_RF, State;

    multi_cycle_control_unit dut (
        .clk(clk), .rst(rst), .Instr(Instr), .NZVC(NZVC), .Mem_Ready(Mem_Ready),
        .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .IorD(IorD), .IR_CE(IR_CE),
        .PC_Write_en(PC_Write_en), .RF_Write_en(RF_Write_en), .ALUOut_CE(ALUOut_CE),
        .ALU_A_Sel(ALU_A_Sel), .ALU_Control(ALU_Control), .MemtoReg(MemtoReg),
        .ALU_B_Sel(ALU_B_Sel), .Imm_Sel(Imm_Sel), .Rd_to_RF(Rd_to_RF),
        .Rm_Rd_to_RF(Rm_Rd_to_RF), .Rn_to_RF(Rn_to_RF), .State(State)
    );

    always #5 clk = ~clk;

`ifdef CTRL_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, mwr, iord, irce, pcwe, rfwe, aoce, asel, actl, m2r;
        logic [1:0] bsel, isel;
        logic [2:0] rd, rm, rn;
    } obs_t;

    obs_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] mflags;          // model of the architectural condition flags

    function automatic obs_t sample();
        obs_t o;
        o.st = State; o.mreq = Mem_Req; o.mwr = Mem_Write; o.iord = IorD; o.irce = IR_CE;
        o.pcwe = PC_Write_en; o.rfwe = RF_Write_en; o.aoce = ALUOut_CE; o.asel = ALU_A_Sel;
        o.actl = ALU_Control; o.m2r = MemtoReg; o.bsel = ALU_B_Sel; o.isel = Imm_Sel;
        o.rd = Rd_to_RF; o.rm = Rm_Rd_to_RF; o.rn = Rn_to_RF;
        return o;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s @%0t: actual=%h (state %0d) required=%h (state %0d)",
                     name, $time, act, act.st, req, req.st);
        end
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    function automatic bit cond_true(input logic [2:0] c, input logic [3:0] f);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return f[2];
            3'd2:    return !f[2];
            3'd3:    return f[3];
            3'd4:    return !f[3];
            3'd5:    return f[0];
            3'd6:    return !f[0];
            default: return f[1];
        endcase
    endfunction

    // Monitor: one expected vector per clock while the scoreboard holds work
    always @(negedge clk) begin : mon
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare("cycle", sample(), e);
        end
    end

    // Reference model for one instruction: builds the cycle-by-cycle expected trace, then drives it
    task automatic run_instr(input logic [15:0] ins, input int wf, input int wm, input logic [3:0] nz);
        obs_t       e, base;
        bit         rdy[$];
        logic [4:0] op;
        bit         alu, ldr, str, br, halt;
        op   = ins[15:11];
        alu  = (op <= 5'd4);
        ldr  = (op == 5'd8);
        str  = (op == 5'd9);
        br   = BR_EN && (op == 5'd16);
        halt = (op == 5'd31);
        base    = '0;
        base.rd = ins[10:8];
        base.rm = (op == 5'd4) ? ins[10:8] : ins[7:5];
        base.rn = str ? ins[10:8] : ins[4:2];

        for (int i = 0; i < wf; i++) begin
            e = '0; e.mreq = 1; e.bsel = 2'b11;
            exp_q.push_back(e); rdy.push_back(1'b0);
        end
        e = '0; e.mreq = 1; e.bsel = 2'b11; e.irce = 1; e.pcwe = 1;
        exp_q.push_back(e); rdy.push_back(1'b1);

        e = base; e.st = 3'd1;
        exp_q.push_back(e); rdy.push_back(1'($urandom_range(0, 1)));

        if (halt) begin
            for (int i = 0; i < 10; i++) begin
                e = '0; e.st = 3'd7;
                exp_q.push_back(e); rdy.push_back(1'($urandom_range(0, 1)));
            end
        end else if (br) begin
            e = base; e.st = 3'd6;
            if (cond_true(ins[10:8], mflags)) begin
                e.bsel = 2'b01; e.isel = 2'b01; e.pcwe = 1;
            end
            exp_q.push_back(e); rdy.push_back(1'($urandom_range(0, 1)));
        end else if (alu || ldr || str) begin
            e = base; e.st = 3'd2; e.asel = 1; e.aoce = 1;
            e.bsel = (op <= 5'd1) ? 2'b00 : 2'b01;
            e.isel = (op == 5'd4) ? 2'b01 : 2'b00;
            e.actl = (op == 5'd1) || (op == 5'd3);
            exp_q.push_back(e); rdy.push_back(1'($urandom_range(0, 1)));
            if (alu) begin
                mflags = nz;
                e = base; e.st = 3'd3; e.rfwe = 1;
                exp_q.push_back(e); rdy.push_back(1'($urandom_range(0, 1)));
            end else begin
                for (int i = 0; i <= wm; i++) begin
                    e = base; e.st = 3'd4; e.mreq = 1; e.iord = 1; e.mwr = str;
                    exp_q.push_back(e); rdy.push_back(i == wm);
                end
                if (ldr) begin
                    e = base; e.st = 3'd5; e.rfwe = 1; e.m2r = 1;
                    exp_q.push_back(e); rdy.push_back(1'($urandom_range(0, 1)));
                end
            end
        end

        for (int k = 0; k < rdy.size(); k++) begin
            Instr = ins; NZVC = nz; Mem_Ready = rdy[k];
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [4:0]  ops [10];
        logic [4:0]  nops [6];
        logic [4:0]  op;
        logic [15:0] ins;
        ops  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd16, 5'd16, 5'd5};
        nops = '{5'd5, 5'd7, 5'd10, 5'd17, 5'd24, 5'd30};

        rst = 1'b1; Instr = 16'h0; NZVC = 4'h0; Mem_Ready = 1'b0; mflags = 4'h0;
        #2 compare("reset_idle", sample(), '0);
        Mem_Ready = 1'b1;
        #1 compare("reset_ready_ignored", sample(), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ADD R3,R5,R6 with immediate memory
        run_instr({5'b00000, 3'd3, 3'd5, 3'd6, 2'b00}, 0, 0, 4'h5);
        // SUBI setting N, then BMI -2 (taken); SUBI clearing flags, then BMI again (not taken)
        run_instr({5'b00011, 3'd1, 3'd2, 5'd3}, 0, 0, 4'b1000);
        run_instr({5'b10000, 3'b011, 8'hFE}, 0, 0, 4'h0);
        run_instr({5'b00011, 3'd1, 3'd2, 5'd3}, 0, 0, 4'b0000);
        run_instr({5'b10000, 3'b011, 8'hFE}, 0, 0, 4'hF);
        // LDR with two wait cycles, STR, NOP behind a 3-cycle fetch stall, ADDI8
        run_instr({5'b01000, 3'd2, 3'd4, 5'd7}, 0, 2, 4'hF);
        run_instr({5'b01001, 3'd6, 3'd1, 5'd2}, 1, 1, 4'h3);
        run_instr({5'b00101, 11'h5A5}, 3, 0, 4'h0);
        run_instr({5'b00100, 3'd7, 8'h81}, 0, 0, 4'b0110);

        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 9)];
            if (op == 5'd5) op = nops[$urandom_range(0, 5)];
            ins = {op, 11'($urandom)};
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom));
        end

        run_instr({5'b11111, 11'h123}, 0, 0, 4'h0);

        // Asynchronous reset in the middle of EXEC
        rst = 1'b1; #1 compare("halt_reset", sample(), '0);
        @(posedge clk); #1 rst = 1'b0; mflags = 4'h0;
        Instr = {5'b00000, 3'd3, 3'd5, 3'd6, 2'b00}; Mem_Ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check3("exec_state", State, 3'd2);
        check3("exec_aluout_ce", {2'b00, ALUOut_CE}, 3'd1);
        rst = 1'b1;
        #1 compare("async_rst_in_exec", sample(), '0);
        @(posedge clk); #1 rst = 1'b0; mflags = 4'h0;

        // Flags cleared by reset: an EQ branch after reset with a plain NOP must not be taken
        run_instr({5'b00110, 11'h0}, 0, 0, 4'hF);
        run_instr({5'b10000, 3'b001, 8'h10}, 1, 0, 4'hF);
        run_instr({5'b10000, 3'b010, 8'h10}, 0, 0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control_unit.md
# multi_cycle_control_unit

Multi-cycle control FSM that drives the 16-bit RF+ALU datapath. It decodes the latched instruction, sequences fetch, decode, execute, memory and write-back, and produces every datapath select and enable: register addresses, ALU operand selects, immediate select, ALU op, register write and ALUOut enable. It also holds the condition flags and resolves conditional branches.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Instr  in  16  instruction register contents. Opcode is [15:11].
- NZVC  in  4  ALU flags: [3]=N, [2]=Z, [1]=V, [0]=C.
- Mem_Ready  in  1  memory completion strobe for the current Mem_Req.
- Mem_Req  out  1  memory access request. Reset value 0.
- Mem_Write  out  1  1 = store. Reset value 0.
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut. Reset value 0.
- IR_CE  out  1  instruction register load. Reset value 0.
- PC_Write_en  out  1  PC load from the ALU result. Reset value 0.
- RF_Write_en, ALUOut_CE, ALU_A_Sel, ALU_Control, MemtoReg  out  1 each. Reset value 0.
- ALU_B_Sel  out  2  00 = RF, 01 = immediate, 10 = constant 0, 11 = constant 1. Reset value 00.
- Imm_Sel  out  2  00 = sext imm5, 01 = sext imm8, 10 = zext imm8, 11 = {imm8, Rd[7:0]}. Reset value 00.
- Rd_to_RF, Rm_Rd_to_RF, Rn_to_RF  out  3 each. Reset value 000.
- State  out  3  current state, for debug. Reset value 0 (FETCH).

## Operation
- Opcodes:
  - 00000 ADD and 00001 SUB: Rd=[10:8], Rm=[7:5], Rn=[4:2].
  - 00010 ADDI and 00011 SUBI: imm5 in [4:0].
  - 00100 ADDI8: Rd = Rd + sext imm8.
  - 01000 LDR Rd,[Rm,#imm5].
  - 01001 STR Rd,[Rm,#imm5]: Rn_to_RF = [10:8] supplies the store data.
  - 10000 Bcc imm8: condition in [10:8].
  - 11111 HALT.
  - Every other opcode is a NOP.
- ALU_Control is 1 only for SUB and SUBI. Every other ALU use is an add.
- FETCH (0):
  - Drives Mem_Req=1, IorD=0, ALU_A_Sel=0, ALU_B_Sel=11.
  - Holds in FETCH while Mem_Ready=0.
  - In the cycle Mem_Ready=1: IR_CE=1 and PC_Write_en=1, then goes to DECODE.
- DECODE (1):
  - Register addresses are driven from Instr from this state until leaving the instruction.
  - Next state: Bcc → BRANCH; HALT → HALT; NOP → FETCH; all others → EXEC.
- EXEC (2):
  - Drives ALU_A_Sel=1, ALUOut_CE=1.
  - ALU_B_Sel: 00 for register forms, 01 otherwise.
  - Imm_Sel: 00 for imm5 forms, 01 for ADDI8.
  - ADD/SUB/ADDI/SUBI/ADDI8 capture NZVC into an internal flag register at the end of this cycle.
  - Next state: LDR/STR → MEM; ALU ops → WB.
- WB (3): RF_Write_en=1, MemtoReg=0, then FETCH.
- MEM (4):
  - Drives Mem_Req=1, IorD=1; Mem_Write=1 for STR.
  - Holds while Mem_Ready=0.
  - When Mem_Ready=1: LDR → LDWB, STR → FETCH.
- LDWB (5): RF_Write_en=1, MemtoReg=1, then FETCH.
- BRANCH (6):
  - Conditions, evaluated on the stored flags: 000 always, 001 EQ (Z), 010 NE, 011 MI (N), 100 PL, 101 CS (C), 110 CC, 111 VS (V).
  - If the condition is true: ALU_A_Sel=0, ALU_B_Sel=01, Imm_Sel=01, PC_Write_en=1. The target is the incremented PC + sext imm8.
  - Then FETCH.
- HALT (7): all enables 0. Only rst exits.
- All enables not listed for a state are 0 in that state.

## Timing
- Outputs are decoded from the registered state and Instr, plus Mem_Ready in FETCH/MEM. No output register stage.
- Instruction cycle counts:
  - ALU op: 4 cycles.
  - STR: 4 cycles.
  - LDR: 5 cycles.
  - Bcc: 3 cycles.
  - NOP: 2 cycles.
  - Each Mem_Ready wait cycle adds 1.
- Mem_Req stays high until Mem_Ready is sampled high. Mem_Ready while Mem_Req=0 is ignored.
- Flag register reset value is 0000. Flags update only in EXEC of ALU ops, so LDR and STR preserve them.
- rst asserted mid-instruction: State=FETCH and all outputs take their reset values immediately. Any pending memory request is dropped.

## Configuration
- CTRL_BRANCH_EN
  - Defined: Bcc is decoded as above.
  - Undefined: opcode 10000 is a NOP (DECODE → FETCH). The flag register and BRANCH state are removed, and the State value 6 is never produced.

## Test plan
- Reset, then Mem_Ready tied to 1 with Instr=ADD R3,R5,R6:
  - State sequence 0,1,2,3,0.
  - ALUOut_CE=1 only in state 2; RF_Write_en=1 only in state 3, with Rd_to_RF=011.
- FETCH with Mem_Ready held low 3 cycles: State stays 0, Mem_Req=1, IR_CE=0 and PC_Write_en=0 until the ready cycle.
- SUBI with NZVC=1000 at EXEC, then BMI imm8=0xFE: BRANCH asserts PC_Write_en=1 with Imm_Sel=01 and ALU_B_Sel=01. Same branch after flags 0000: PC_Write_en stays 0.
- LDR with a 2-cycle memory wait:
  - MEM holds with IorD=1 and Mem_Write=0.
  - LDWB then asserts RF_Write_en=1, MemtoReg=1.
  - Total 7 cycles.
- STR: Mem_Write=1 in MEM, RF_Write_en never asserted. HALT: State stays 7 for 10 cycles. Asynchronous rst pulse in EXEC: State=0 and ALUOut_CE=0 before the next edge.
